// File: rtl/prime_seq_pkg.sv
// Shared definitions for the prime sequence monitor.
// Contents: FSM state encoding, the prime table (2,3,5,7,11,13),
// the table index constants and the error cause codes.
package prime_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam int unsigned NUM_PRIMES = 6;

    // Legal values in ascending order; a table position is the index output
    localparam logic [4:0] PRIME_TABLE [NUM_PRIMES] = '{
        5'd2, 5'd3, 5'd5, 5'd7, 5'd11, 5'd13
    };

    localparam logic [2:0] IDX_FIRST = 3'd0;   // position of 2
    localparam logic [2:0] IDX_LAST  = 3'd5;   // position of 13
    localparam logic [2:0] IDX_NONE  = 3'd7;   // value not in the table

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_NONPRIME = 2'b01;
    localparam logic [1:0] ERR_SKIP     = 2'b10;

endpackage

// File: rtl/prime_index_lut.sv
// Combinational lookup of a 5-bit value in the prime table.
// Ports:
//   value    in  5  value to look up
//   index    out 3  table position (0..5), IDX_NONE when not prime
//   is_prime out 1  value is one of 2,3,5,7,11,13
module prime_index_lut
    import prime_seq_pkg::*;
(
    input  logic [4:0] value,
    output logic [2:0] index,
    output logic       is_prime
);

    always_comb begin
        index    = IDX_NONE;
        is_prime = 1'b0;
        for (int unsigned i = 0; i < NUM_PRIMES; i++) begin
            if (value == PRIME_TABLE[i]) begin
                index    = 3'(i);
                is_prime = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prime_seq_monitor.sv
// Monitors the output of an upstream prime counter and checks that each
// sample either holds or steps to the neighbouring prime in the direction
// the counter was driven one cycle earlier.
// Ports:
//   clock      in  1       rising-edge clock
//   reset      in  1       synchronous active-high reset
//   direction  in  1       direction driven upstream (0 up, 1 down)
//   number     in  5       upstream value, [0:4], bit 0 = MSB
//   clear_err  in  1       leave ERROR state
//   tracking   out 1       state is TRACK
//   index      out 3       table position of last sample (7 = non-prime)
//   at_end     out 1       last sample sits on the endpoint for dir_q
//   done       out 1       pulse: advancing legal step onto the endpoint
//   step_count out STEP_W  legal advancing steps since entering TRACK
//   error      out 1       state is ERROR
//   error_code out 2       first error cause (01 non-prime, 10 skip)
module prime_seq_monitor
    import prime_seq_pkg::*;
#(
    parameter int unsigned STEP_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              direction,
    input  logic [0:4]        number,
    input  logic              clear_err,
    output logic              tracking,
    output logic [2:0]        index,
    output logic              at_end,
    output logic              done,
    output logic [STEP_W-1:0] step_count,
    output logic              error,
    output logic [1:0]        error_code
);

    state_t     state;
    logic       dir_q;
    logic [4:0] prev;
    logic [4:0] sample;
    logic [2:0] idx_n;
    logic       prime_n;
    logic       hold;
    logic       advance;
    logic       endpoint;

    // number[0] is the MSB, so a plain assignment keeps the numeric value
    assign sample = number;

    prime_index_lut u_lut (
        .value    (sample),
        .index    (idx_n),
        .is_prime (prime_n)
    );

    // The index register already holds the table position of prev, so the
    // successor check is a +/-1 compare against it instead of a second lookup.
    always_comb begin
        hold     = (sample == prev);
        advance  = 1'b0;
        endpoint = 1'b0;
        if (dir_q) begin
            advance  = prime_n && (index != IDX_FIRST) && (idx_n == index - 3'd1);
            endpoint = (idx_n == IDX_FIRST);
        end else begin
            advance  = prime_n && (index != IDX_LAST) && (idx_n == index + 3'd1);
            endpoint = (idx_n == IDX_LAST);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            dir_q      <= 1'b0;
            prev       <= '0;
            tracking   <= 1'b0;
            index      <= '0;
            at_end     <= 1'b0;
            done       <= 1'b0;
            step_count <= '0;
            error      <= 1'b0;
            error_code <= ERR_NONE;
        end else begin
            dir_q  <= direction;
            prev   <= sample;
            index  <= idx_n;
            at_end <= endpoint;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (prime_n) begin
                        state      <= ST_TRACK;
                        tracking   <= 1'b1;
                        step_count <= '0;
                    end
                end
                ST_TRACK: begin
                    // clear_err is ignored here, so a detected error always wins
                    if (!prime_n) begin
                        state      <= ST_ERROR;
                        tracking   <= 1'b0;
                        error      <= 1'b1;
                        error_code <= ERR_NONPRIME;
                    end else if (advance) begin
                        if (step_count != '1) begin
                            step_count <= step_count + 1'b1;
                        end
                        done <= endpoint;
                    end else if (!hold) begin
                        state      <= ST_ERROR;
                        tracking   <= 1'b0;
                        error      <= 1'b1;
                        error_code <= ERR_SKIP;
                    end
                end
                ST_ERROR: begin
                    if (clear_err) begin
                        state      <= ST_IDLE;
                        error      <= 1'b0;
                        error_code <= ERR_NONE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    tracking <= 1'b0;
                    error    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_seq_monitor.sv
// Scoreboard bench for prime_seq_monitor: each driven cycle pushes the
// expected outputs, which are popped and compared after the clock edge.
// A second instance with STEP_W = 2 checks counter saturation.
module tb_prime_seq_monitor;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       direction = 1'b0;
    logic [0:4] number = '0;
    logic       clear_err = 1'b0;

    logic       tracking, at_end, done, error;
    logic [2:0] index;
    logic [7:0] step_count;
    logic [1:0] error_code;

    logic       tracking2, at_end2, done2, error2;
    logic [2:0] index2;
    logic [1:0] step_count2;
    logic [1:0] error_code2;

    prime_seq_monitor #(.STEP_W(8)) u_dut (
        .clock(clock), .reset(reset), .direction(direction), .number(number),
        .clear_err(clear_err), .tracking(tracking), .index(index), .at_end(at_end),
        .done(done), .step_count(step_count), .error(error), .error_code(error_code)
    );

    prime_seq_monitor #(.STEP_W(2)) u_dut2 (
        .clock(clock), .reset(reset), .direction(direction), .number(number),
        .clear_err(clear_err), .tracking(tracking2), .index(index2), .at_end(at_end2),
        .done(done2), .step_count(step_count2), .error(error2), .error_code(error_code2)
    );

    always #5 clock = ~clock;

    typedef struct {
        int tracking;
        int index;
        int at_end;
        int done;
        int cnt8;
        int cnt2;
        int error;
        int code;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    int primes [6] = '{2, 3, 5, 7, 11, 13};

    // model state: 0 idle, 1 track, 2 error
    int m_state = 0;
    int m_dir   = 0;
    int m_prev  = 0;
    int m_cnt   = 0;
    int m_code  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int pos_of(input int v);
        for (int i = 0; i < 6; i++)
            if (primes[i] == v) return i;
        return 7;
    endfunction

    function automatic int succ_of(input int p, input int d);
        int k;
        k = pos_of(p);
        if (k == 7) return -1;
        if (d == 0 && k < 5) return primes[k + 1];
        if (d == 1 && k > 0) return primes[k - 1];
        return -1;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Drive one cycle, push the expectation, then pop and compare after the edge.
    task automatic cyc(input int rst, input int dir, input int num, input int clr);
        exp_t e;
        int   isp, endp, adv;
        reset     = rst[0];
        direction = dir[0];
        number    = num[4:0];
        clear_err = clr[0];
        e.done = 0;
        if (rst != 0) begin
            m_state = 0; m_dir = 0; m_prev = 0; m_cnt = 0; m_code = 0;
            e.index = 0;
            e.at_end = 0;
        end else begin
            isp  = (pos_of(num) != 7) ? 1 : 0;
            endp = ((m_dir == 0 && num == 13) || (m_dir == 1 && num == 2)) ? 1 : 0;
            adv  = (succ_of(m_prev, m_dir) == num) ? 1 : 0;
            case (m_state)
                0: if (isp != 0) begin m_state = 1; m_cnt = 0; end
                1: begin
                    if (isp == 0) begin m_state = 2; m_code = 1; end
                    else if (num == m_prev) begin end
                    else if (adv != 0) begin m_cnt++; e.done = endp; end
                    else begin m_state = 2; m_code = 2; end
                end
                default: if (clr != 0) begin m_state = 0; m_code = 0; end
            endcase
            e.index  = pos_of(num);
            e.at_end = endp;
            m_prev = num;
            m_dir  = dir;
        end
        e.tracking = (m_state == 1) ? 1 : 0;
        e.error    = (m_state == 2) ? 1 : 0;
        e.code     = m_code;
        e.cnt8     = min_i(m_cnt, 255);
        e.cnt2     = min_i(m_cnt, 3);
        sb.push_back(e);

        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("tracking",    32'(tracking),    e.tracking);
            check("index",       32'(index),       e.index);
            check("at_end",      32'(at_end),      e.at_end);
            check("done",        32'(done),        e.done);
            check("step_count",  32'(step_count),  e.cnt8);
            check("error",       32'(error),       e.error);
            check("error_code",  32'(error_code),  e.code);
            check("step_count2", 32'(step_count2), e.cnt2);
            check("done2",       32'(done2),       e.done);
        end
    endtask

    int up_seq [6]   = '{2, 3, 5, 7, 11, 13};
    int down_seq [6] = '{13, 11, 7, 5, 3, 2};
    int pool [10]    = '{2, 3, 5, 7, 11, 13, 4, 9, 0, 31};

    initial begin
        // reset state
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);

        // ascending full walk, done on 13, hold without re-pulse
        for (int i = 0; i < 6; i++) cyc(0, 0, up_seq[i], 0);
        cyc(0, 0, 13, 0);
        cyc(0, 0, 13, 0);

        // descending full walk, at_end held on 2
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, down_seq[i], 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 2, 0);

        // skip 5 -> 11, frozen state, clear back to IDLE, re-enter TRACK
        cyc(1, 0, 0, 0);
        cyc(0, 0, 2, 0); cyc(0, 0, 3, 0); cyc(0, 0, 5, 0);
        cyc(0, 0, 11, 0);
        cyc(0, 0, 13, 0);
        cyc(0, 0, 11, 1);
        cyc(0, 0, 11, 0);

        // non-prime from TRACK, then error vs clear_err in the same cycle
        cyc(0, 0, 9, 0);
        cyc(0, 0, 9, 1);
        cyc(0, 0, 3, 0);
        cyc(0, 0, 4, 1);
        cyc(0, 0, 4, 0);
        // reset while in ERROR
        cyc(1, 0, 4, 1);

        // direction reversal and long hold at the endpoint
        cyc(0, 0, 2, 0); cyc(0, 0, 3, 0); cyc(0, 0, 5, 0); cyc(0, 0, 7, 0);
        cyc(0, 1, 7, 0);
        cyc(0, 1, 5, 0); cyc(0, 1, 3, 0);
        cyc(0, 0, 3, 0);
        cyc(0, 0, 5, 0); cyc(0, 0, 7, 0); cyc(0, 0, 11, 0); cyc(0, 0, 13, 0);
        for (int i = 0; i < 300; i++) cyc(0, 0, 13, 0);

        // no wrap: 13 -> 2 ascending is a skip
        cyc(0, 0, 2, 0);
        cyc(0, 0, 2, 1);

        // saturation of the narrow counter, then reset mid-sequence
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, up_seq[i], 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 2, 0); cyc(0, 0, 3, 0); cyc(0, 0, 5, 0);
        cyc(1, 0, 7, 0);

        // random walk mixing holds, neighbours, jumps and clears
        for (int i = 0; i < 200; i++) begin
            int r, v;
            r = $urandom_range(0, 9);
            if (r < 6 && m_prev != 0 && succ_of(m_prev, m_dir) > 0)
                v = succ_of(m_prev, m_dir);
            else if (r < 8)
                v = m_prev;
            else
                v = pool[$urandom_range(0, 9)];
            cyc(($urandom_range(0, 60) == 0) ? 1 : 0, int'($urandom_range(0, 9) == 0) ^ m_dir,
                v, ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/prime_seq_monitor.md
PRIME_SEQ_MONITOR -- requirements
Module: prime_seq_monitor

Interface
REQ-001 SHALL have parameter STEP_W, default 8, width of the legal-step counter.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 SHALL have port direction  input  1  direction driven to the upstream prime counter (0 = ascending, 1 = descending).
REQ-005 SHALL have port number  input  5  upstream counter value, [0:4] ordering, bit 0 = MSB.
REQ-006 SHALL have port clear_err  input  1  leaves ERROR state; ignored in other states.
REQ-007 SHALL have port tracking  output  1  high while state = TRACK.
REQ-008 SHALL have port index  output  3  table position of last sample (2->0, 3->1, 5->2, 7->3, 11->4, 13->5, non-prime->7).
REQ-009 SHALL have port at_end  output  1  last sample is 13 with dir_q=0 or 2 with dir_q=1.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a legal step lands on the endpoint.
REQ-011 SHALL have port step_count  output  STEP_W  number of legal advancing steps since entering TRACK.
REQ-012 SHALL have port error  output  1  sticky error flag, high while state = ERROR.
REQ-013 SHALL have port error_code  output  2  first error cause: 00 none, 01 NONPRIME, 10 SKIP.

Function
REQ-014 SHALL sample number every rising edge; all outputs SHALL be registered and reflect the sample taken at that edge (1-cycle latency).
REQ-015 SHALL register direction each cycle into dir_q; step legality SHALL use dir_q (direction one cycle earlier), matching the one-cycle upstream update.
REQ-016 SHALL register the previous sample as prev.
REQ-017 Legal transition: n == prev (hold), or n == successor(prev, dir_q) in table 2,3,5,7,11,13; no wrap-around (13 up and 2 down have no successor, only hold is legal).
REQ-018 States: IDLE, TRACK, ERROR.
REQ-019 IDLE: prime sample -> TRACK, step_count = 0; non-prime sample -> stay IDLE, no error.
REQ-020 TRACK: legal advancing step -> step_count + 1, saturating at 2^STEP_W-1; hold -> unchanged.
REQ-021 TRACK: non-prime sample -> ERROR, error_code = 01; prime but illegal transition -> ERROR, error_code = 10.
REQ-022 ERROR: error_code and step_count frozen; index and at_end keep tracking samples; clear_err -> IDLE next edge, error and error_code cleared.
REQ-023 Error detection and clear_err in the same cycle while in TRACK: error wins (-> ERROR).
REQ-024 done SHALL pulse only in TRACK on an advancing legal step onto the endpoint; holding at the endpoint SHALL NOT re-pulse.
REQ-025 Direction change without reset: walking back from current value is legal once dir_q reflects the change.

Reset
REQ-026 reset high SHALL force, on the next rising edge: state IDLE, dir_q 0, prev 0, tracking 0, index 0, at_end 0, done 0, step_count 0, error 0, error_code 00.
REQ-027 reset SHALL take priority over all other inputs, including mid-sequence and in ERROR.
REQ-028 First sample after reset deasserts SHALL be handled per IDLE rules (no transition check).

Structure
REQ-029 Shared package prime_seq_pkg SHALL hold the state encoding, prime table constants (2,3,5,7,11,13), index constants, and error codes.
REQ-030 Sub-module prime_index_lut SHALL map a 5-bit value to index and an is_prime flag (combinational); successor lookup SHALL reuse index +/-1.

Verification
REQ-031 Reset, then number 2,3,5,7,11,13, direction 0 -> tracking 1, step_count 5, done pulse on the cycle after 13 is sampled, error 0.
REQ-032 Reset with direction 1, number 13,11,7,5,3,2 -> step_count 5, done pulse on 2, at_end 1 while 2 holds.
REQ-033 In TRACK at 5, number jumps to 11 -> error 1, error_code 10, step_count frozen; clear_err -> error 0, IDLE next cycle.
REQ-034 In TRACK, number = 9 -> error_code 01, index 7; number = 4 simultaneous with clear_err from TRACK -> stays ERROR.
REQ-035 Ascending to 7, direction toggles to 1 -> 7 held, then 5,3 accepted legally; 13 held with dir_q 0 for 300 cycles -> no extra done, no error.
REQ-036 STEP_W = 2, 5 legal steps -> step_count saturates at 3; reset mid-sequence -> all outputs zero next edge.
